// File: rtl/tournament_predictor_gen2.sv
// Tournament branch predictor: gshare + bimodal components with a per-PC meta chooser,
// owning the global history register and a saturating mispredict counter.
module tournament_predictor_gen2 #(
    parameter int unsigned PC_WIDTH      = 16,
    parameter int unsigned INDEX_WIDTH   = 12,
    parameter int unsigned HISTORY_WIDTH = 12,
    parameter logic [1:0]  GSHARE_INIT   = 2'b01,
    parameter logic [1:0]  BIMODAL_INIT  = 2'b01,
    parameter logic [1:0]  META_INIT     = 2'b10,
    parameter int unsigned STAT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic                     predict_valid,
    input  logic [PC_WIDTH-1:0]      predict_pc,
    output logic                     pred_valid,
    output logic                     pred_taken,
    output logic                     pred_g,
    output logic                     pred_p,
    output logic [HISTORY_WIDTH-1:0] pred_ghr,
    input  logic                     update_valid,
    input  logic [PC_WIDTH-1:0]      update_pc,
    input  logic                     update_taken,
    input  logic                     update_g,
    input  logic                     update_p,
    input  logic [HISTORY_WIDTH-1:0] update_ghr,
    output logic [STAT_WIDTH-1:0]    mispredicts
);

    localparam int unsigned DEPTH = 2 ** INDEX_WIDTH;
    localparam logic [0:0]  ST_INIT = 1'b0;
    localparam logic [0:0]  ST_RUN  = 1'b1;

    logic [0:0]               state;
    logic [0:0]               state_next;
    logic [INDEX_WIDTH-1:0]   sweep_idx;
    logic [HISTORY_WIDTH-1:0] ghr;

    logic [1:0] gshare_tbl  [DEPTH];
    logic [1:0] bimodal_tbl [DEPTH];
    logic [1:0] meta_tbl    [DEPTH];

    logic                   run;
    logic                   do_pred;
    logic                   do_upd;
    logic [INDEX_WIDTH-1:0] p_pidx;
    logic [INDEX_WIDTH-1:0] p_gidx;
    logic [INDEX_WIDTH-1:0] u_pidx;
    logic [INDEX_WIDTH-1:0] u_gidx;
    logic [1:0]             u_g_cnt;
    logic [1:0]             u_p_cnt;
    logic [1:0]             u_m_cnt;
    logic [1:0]             g_new;
    logic [1:0]             p_new;
    logic [1:0]             m_new;
    logic                   gc;
    logic                   pc_ok;
    logic                   u_final;
    logic                   p_g_bit;
    logic                   p_p_bit;
    logic                   p_m_bit;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    if (PC_WIDTH > INDEX_WIDTH) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = ^{predict_pc[PC_WIDTH-1:INDEX_WIDTH],
                                update_pc[PC_WIDTH-1:INDEX_WIDTH]};
    end

    assign run     = (state == ST_RUN);
    assign do_pred = run & predict_valid;
    assign do_upd  = run & update_valid;

    // History occupies the low index bits of the gshare hash.
    assign p_pidx = predict_pc[INDEX_WIDTH-1:0];
    assign p_gidx = p_pidx ^ INDEX_WIDTH'(ghr);
    assign u_pidx = update_pc[INDEX_WIDTH-1:0];
    assign u_gidx = u_pidx ^ INDEX_WIDTH'(update_ghr);

    assign p_g_bit = gshare_tbl[p_gidx][1];
    assign p_p_bit = bimodal_tbl[p_pidx][1];
    assign p_m_bit = meta_tbl[p_pidx][1];

    assign u_g_cnt = gshare_tbl[u_gidx];
    assign u_p_cnt = bimodal_tbl[u_pidx];
    assign u_m_cnt = meta_tbl[u_pidx];
    assign g_new   = sat_step(u_g_cnt, update_taken);
    assign p_new   = sat_step(u_p_cnt, update_taken);
    assign gc      = (update_g == update_taken);
    assign pc_ok   = (update_p == update_taken);
    assign u_final = u_m_cnt[1] ? update_p : update_g;

    // Meta moves toward whichever component alone was right.
    always_comb begin
        m_new = u_m_cnt;
        if (gc && !pc_ok) begin
            m_new = sat_step(u_m_cnt, 1'b0);
        end else if (!gc && pc_ok) begin
            m_new = sat_step(u_m_cnt, 1'b1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (sweep_idx == {INDEX_WIDTH{1'b1}}) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            sweep_idx   <= '0;
            ghr         <= '0;
            mispredicts <= '0;
            ready       <= 1'b0;
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_g      <= 1'b0;
            pred_p      <= 1'b0;
            pred_ghr    <= '0;
        end else begin
            state      <= state_next;
            ready      <= (state_next == ST_RUN);
            pred_valid <= do_pred;
            if (state == ST_INIT) begin
                sweep_idx <= sweep_idx + INDEX_WIDTH'(1);
            end
            if (do_pred) begin
                pred_g     <= p_g_bit;
                pred_p     <= p_p_bit;
                pred_taken <= p_m_bit ? p_p_bit : p_g_bit;
                pred_ghr   <= ghr;
            end
            if (do_upd) begin
                ghr <= HISTORY_WIDTH'({update_ghr, update_taken});
                if (u_final != update_taken && mispredicts != {STAT_WIDTH{1'b1}}) begin
                    mispredicts <= mispredicts + STAT_WIDTH'(1);
                end
            end
        end
    end

    // Counter tables: sweep writes during INIT, single-cycle read-modify-write in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                gshare_tbl[sweep_idx]  <= GSHARE_INIT;
                bimodal_tbl[sweep_idx] <= BIMODAL_INIT;
                meta_tbl[sweep_idx]    <= META_INIT;
            end else if (do_upd) begin
                gshare_tbl[u_gidx]  <= g_new;
                bimodal_tbl[u_pidx] <= p_new;
                meta_tbl[u_pidx]    <= m_new;
            end
        end
    end

endmodule

// File: tb/tb_tournament_predictor_gen2.sv
// Directed vector bench for tournament_predictor_gen2 with 16-entry tables and a 2-bit stat counter.
module tb_tournament_predictor_gen2;

    localparam int unsigned PW = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned HW = 4;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic          predict_valid;
    logic [PW-1:0] predict_pc;
    logic          pred_valid;
    logic          pred_taken;
    logic          pred_g;
    logic          pred_p;
    logic [HW-1:0] pred_ghr;
    logic          update_valid;
    logic [PW-1:0] update_pc;
    logic          update_taken;
    logic          update_g;
    logic          update_p;
    logic [HW-1:0] update_ghr;
    logic [SW-1:0] mispredicts;

    tournament_predictor_gen2 #(
        .PC_WIDTH(PW), .INDEX_WIDTH(IW), .HISTORY_WIDTH(HW),
        .GSHARE_INIT(2'b01), .BIMODAL_INIT(2'b01), .META_INIT(2'b10),
        .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .predict_valid(predict_valid), .predict_pc(predict_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_g(pred_g),
        .pred_p(pred_p), .pred_ghr(pred_ghr),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_g(update_g), .update_p(update_p),
        .update_ghr(update_ghr), .mispredicts(mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pv;
        logic [PW-1:0] ppc;
        logic          uv;
        logic [PW-1:0] upc;
        logic          ut;
        logic          ug;
        logic          up;
        logic [HW-1:0] ughr;
        logic          e_pv;
        logic          e_t;
        logic          e_g;
        logic          e_p;
        logic [HW-1:0] e_ghr;
        logic [SW-1:0] e_misp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic pv, input int ppc, input logic uv, input int upc,
                       input logic ut, input logic ug, input logic up, input int ughr,
                       input logic e_pv, input logic e_t, input logic e_g, input logic e_p,
                       input int e_ghr, input int e_misp);
        vec_t v;
        v.pv = pv;     v.ppc = PW'(ppc);  v.uv = uv;   v.upc = PW'(upc);
        v.ut = ut;     v.ug = ug;         v.up = up;   v.ughr = HW'(ughr);
        v.e_pv = e_pv; v.e_t = e_t;       v.e_g = e_g; v.e_p = e_p;
        v.e_ghr = HW'(e_ghr); v.e_misp = SW'(e_misp);
        vecs.push_back(v);
    endtask

    task automatic set_update(input logic uv, input int upc, input logic ut,
                              input logic ug, input logic up, input int ughr);
        update_valid = uv; update_pc = PW'(upc); update_taken = ut;
        update_g = ug; update_p = up; update_ghr = HW'(ughr);
    endtask

    task automatic chk_pred(input string name, input int idx, input logic t,
                            input logic g, input logic p, input int ghr);
        chk({name, "_valid"}, idx, 32'(pred_valid), 32'd1);
        chk({name, "_taken"}, idx, 32'(pred_taken), 32'(t));
        chk({name, "_g"}, idx, 32'(pred_g), 32'(g));
        chk({name, "_p"}, idx, 32'(pred_p), 32'(p));
        chk({name, "_ghr"}, idx, 32'(pred_ghr), 32'(ghr));
    endtask

    initial begin
        // Reset, then full sweep with predictions requested every cycle
        reset = 1'b1; predict_valid = 1'b1; predict_pc = '0;
        set_update(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("rst_ready", 0, 32'(ready), 32'd0);
        chk("rst_pvalid", 0, 32'(pred_valid), 32'd0);
        chk("rst_misp", 0, 32'(mispredicts), 32'd0);
        chk("rst_ghr", 0, 32'(pred_ghr), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("sweep_ready", i, 32'(ready), 32'(i == 16));
            chk("sweep_pvalid", i, 32'(pred_valid), 32'd0);
        end
        step();
        chk_pred("first_pred", 0, 1'b0, 1'b0, 1'b0, 0);

        //   pv ppc    uv upc    ut ug up ghr   epv et eg ep eghr misp
        add(0, 0,     1, 5,     1, 1, 1, 0,    0, 0, 0, 0, 0, 0);  // bimodal[5] 01->10
        add(0, 0,     1, 5,     1, 1, 1, 0,    0, 0, 0, 0, 0, 0);  // ->11
        add(0, 0,     1, 5,     1, 1, 1, 0,    0, 0, 0, 0, 0, 0);  // saturates at 11
        add(1, 5,     0, 0,     0, 0, 0, 0,    1, 1, 0, 1, 1, 0);
        add(0, 0,     1, 5,     0, 0, 0, 0,    0, 0, 0, 0, 0, 0);  // ->10
        add(1, 5,     0, 0,     0, 0, 0, 0,    1, 1, 1, 1, 0, 0);
        add(0, 0,     1, 'h10,  1, 1, 0, 0,    0, 0, 0, 0, 0, 1);  // meta 10->01, final wrong
        add(0, 0,     1, 'h10,  1, 1, 0, 0,    0, 0, 0, 0, 0, 1);  // meta ->00
        add(0, 0,     1, 'h10,  1, 1, 0, 0,    0, 0, 0, 0, 0, 1);
        add(0, 0,     1, 'h10,  1, 1, 0, 0,    0, 0, 0, 0, 0, 1);
        add(1, 'h10,  0, 0,     0, 0, 0, 0,    1, 0, 0, 1, 1, 1);  // follows gshare now
        add(0, 0,     1, 'h10,  1, 1, 1, 0,    0, 0, 0, 0, 0, 1);  // GHR repair sequence
        add(0, 0,     1, 'h10,  1, 1, 1, 1,    0, 0, 0, 0, 0, 1);
        add(0, 0,     1, 'h10,  0, 0, 0, 3,    0, 0, 0, 0, 0, 1);  // gshare[3] 01->00
        add(1, 5,     0, 0,     0, 0, 0, 0,    1, 1, 0, 1, 6, 1);
        add(0, 0,     1, 3,     1, 1, 1, 0,    0, 0, 0, 0, 0, 1);  // gshare[3] 00->01
        add(1, 2,     0, 0,     0, 0, 0, 0,    1, 0, 0, 0, 1, 1);
        add(1, 7,     1, 7,     1, 1, 1, 1,    1, 0, 0, 0, 1, 1);  // same-cycle collision
        add(1, 7,     0, 0,     0, 0, 0, 0,    1, 1, 0, 1, 3, 1);
        add(0, 0,     1, 9,     0, 0, 0, 0,    0, 0, 0, 0, 0, 1);  // back-to-back accumulate
        add(0, 0,     1, 9,     0, 0, 0, 0,    0, 0, 0, 0, 0, 1);
        add(0, 0,     1, 9,     1, 1, 1, 0,    0, 0, 0, 0, 0, 1);
        add(0, 0,     1, 9,     1, 1, 1, 0,    0, 0, 0, 0, 0, 1);
        add(1, 9,     0, 0,     0, 0, 0, 0,    1, 1, 0, 1, 1, 1);

        foreach (vecs[i]) begin
            predict_valid = vecs[i].pv;
            predict_pc    = vecs[i].ppc;
            set_update(vecs[i].uv, int'(vecs[i].upc), vecs[i].ut, vecs[i].ug,
                       vecs[i].up, int'(vecs[i].ughr));
            step();
            chk("vec_pvalid", i, 32'(pred_valid), 32'(vecs[i].e_pv));
            chk("vec_misp", i, 32'(mispredicts), 32'(vecs[i].e_misp));
            if (vecs[i].e_pv) begin
                chk("vec_taken", i, 32'(pred_taken), 32'(vecs[i].e_t));
                chk("vec_g", i, 32'(pred_g), 32'(vecs[i].e_g));
                chk("vec_p", i, 32'(pred_p), 32'(vecs[i].e_p));
                chk("vec_ghr", i, 32'(pred_ghr), 32'(vecs[i].e_ghr));
            end
        end

        // Reset mid-operation, then again at sweep index 7; requests stay active throughout
        reset = 1'b1; predict_valid = 1'b1; predict_pc = '0;
        set_update(1'b1, 'hA, 1'b1, 1'b0, 1'b0, 0);
        step();
        chk("rst2_ready", 0, 32'(ready), 32'd0);
        chk("rst2_pvalid", 0, 32'(pred_valid), 32'd0);
        chk("rst2_taken", 0, 32'(pred_taken), 32'd0);
        chk("rst2_p", 0, 32'(pred_p), 32'd0);
        chk("rst2_ghr", 0, 32'(pred_ghr), 32'd0);
        chk("rst2_misp", 0, 32'(mispredicts), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("part_ready", i, 32'(ready), 32'd0);
            chk("part_misp", i, 32'(mispredicts), 32'd0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("resweep_ready", i, 32'(ready), 32'(i == 16));
            chk("resweep_pvalid", i, 32'(pred_valid), 32'd0);
            chk("resweep_misp", i, 32'(mispredicts), 32'd0);
        end
        set_update(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk_pred("resweep_pred", 0, 1'b0, 1'b0, 1'b0, 0);

        // Five mispredicted updates saturate the 2-bit counter at 3
        predict_valid = 1'b0;
        set_update(1'b1, 'hA, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("stat_sat", i, 32'(mispredicts), 32'((i < 3) ? i : 3));
        end
        set_update(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tournament_predictor_gen2.md
Name: tournament_predictor_gen2

Overview:
- Parametrised tournament branch predictor with three internal tables of 2-bit saturating counters:
  - gshare table, indexed by PC xor global history.
  - Bimodal (per-PC local) table.
  - Meta chooser table, indexed by PC.
- Owns the global history register (GHR) and a mispredict statistics counter.
- Clears all tables with a post-reset sweep.
- Sits between fetch (predict port) and branch resolution in execute (update port). The history snapshot travels down the pipeline with each branch.

Parameters:
- PC_WIDTH, 16, width of PC inputs.
- INDEX_WIDTH, 12, table index width; each table has 2^INDEX_WIDTH entries.
- HISTORY_WIDTH, 12, GHR width; legal range 1..INDEX_WIDTH.
- GSHARE_INIT, 2'b01, gshare counter value after sweep.
- BIMODAL_INIT, 2'b01, bimodal counter value after sweep.
- META_INIT, 2'b10, meta counter value after sweep.
- STAT_WIDTH, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high once the init sweep has completed.
- predict_valid  in  1  prediction request.
- predict_pc  in  PC_WIDTH  PC of the fetched branch.
- pred_valid  out  1  prediction outputs valid (one cycle after request).
- pred_taken  out  1  final tournament prediction.
- pred_g  out  1  gshare component prediction.
- pred_p  out  1  bimodal component prediction.
- pred_ghr  out  HISTORY_WIDTH  GHR value used for this prediction.
- update_valid  in  1  resolved branch.
- update_pc  in  PC_WIDTH  PC of the resolved branch.
- update_taken  in  1  actual outcome.
- update_g  in  1  pred_g returned with this branch.
- update_p  in  1  pred_p returned with this branch.
- update_ghr  in  HISTORY_WIDTH  pred_ghr returned with this branch.
- mispredicts  out  STAT_WIDTH  saturating count of final mispredictions.

Behaviour:
- Reset sets:
  - State to INIT, sweep index to 0, GHR to 0, mispredicts to 0.
  - ready=0, pred_valid=0, pred_taken=0, pred_g=0, pred_p=0, pred_ghr=0.
- Reset mid-operation, including mid-sweep, restarts the sweep from index 0.
- States:
  - INIT: each cycle writes GSHARE_INIT, BIMODAL_INIT and META_INIT at the sweep index, then increments the index. After writing index 2^INDEX_WIDTH-1, go to RUN on the next edge.
  - RUN: ready=1; stays in RUN until reset.
  - INIT lasts exactly 2^INDEX_WIDTH cycles. ready rises the cycle after the last write.
- Requests in INIT:
  - predict_valid is ignored; pred_valid stays 0.
  - update_valid is ignored; no table, GHR or stat change.
- Index calculation:
  - pidx = pc[INDEX_WIDTH-1:0].
  - gidx = pc[INDEX_WIDTH-1:0] xor zero-extended ghr. The GHR sits in the low bits.
- Predict (RUN, predict_valid=1 at cycle N), outputs registered at N+1:
  - pred_g = MSB of gshare[gidx(predict_pc, current GHR)].
  - pred_p = MSB of bimodal[pidx].
  - pred_taken = pred_p if the meta[pidx] MSB is 1, else pred_g.
  - pred_ghr = current GHR.
  - pred_valid=1 for one cycle.
- If predict_valid=0, pred_valid=0 next cycle and the other outputs hold their values.
- Update (RUN, update_valid=1):
  - gshare[gidx(update_pc, update_ghr)] += 1 if taken, -= 1 if not taken; saturates at 00 and 11.
  - bimodal[pidx(update_pc)]: same rule.
  - Meta, with gc = (update_g==update_taken) and pc_ok = (update_p==update_taken):
    - gc & !pc_ok: decrement, saturating at 00.
    - !gc & pc_ok: increment, saturating at 11.
    - Otherwise: unchanged.
  - GHR <= {update_ghr[HISTORY_WIDTH-2:0], update_taken}, i.e. repaired from the snapshot. When HISTORY_WIDTH=1, GHR <= update_taken.
  - The final prediction is recomputed as update_p if the pre-update meta MSB is 1, else update_g. If it differs from update_taken, mispredicts += 1, saturating at all ones.
- Simultaneous predict and update in the same cycle:
  - The prediction reads pre-update table contents and the pre-update GHR (read-before-write).
  - The update is fully applied at the same edge.
- Read-modify-write of table entries completes in one cycle. Back-to-back updates to the same entry must accumulate: two taken updates from 00 yield 10.

Test Plan:
- Reset sweep: INDEX_WIDTH=4, pulse reset, then predict every cycle -> ready=0 and pred_valid=0 for 16 cycles; ready=1 at cycle 17; first prediction has pred_g=0, pred_p=0, pred_taken=0 (meta 10 selects bimodal).
- Saturation: three taken updates at pc=0x0005 with ghr=0 -> bimodal[5]=11; predict pc=0x0005 -> pred_p=1, pred_taken=1; one not-taken update -> 10, still predicts taken.
- Meta training: four updates at pc=0x0010, update_g=taken, update_p=wrong -> meta goes 10→01→00→00 (saturates); final prediction now follows pred_g.
- GHR repair: updates with taken=1,1,0 and ghr snapshots 0, 1, 3 -> pred_ghr=0b110; gshare entry written at index 0x010 xor 3 for the third update.
- Collision: predict and update the same pc in the same cycle, bimodal 01 → 10 -> same-cycle prediction pred_p=0; next prediction pred_p=1.
- Reset mid-sweep and stats: assert reset at sweep index 7 -> index restarts at 0, ready delayed by a full 16 cycles; with STAT_WIDTH=2, five mispredicted updates -> mispredicts=3.
